// File: rtl/connector_pkg.sv
// Shared types and widths for the trace connector datapath.
// Decoded uop entries, trap info and the encoder instruction-block payload.
package connector_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IRETIRE_LEN = 32;
  localparam int unsigned ITYPE_LEN   = 4;
  localparam int unsigned PRIV_LEN    = 2;
  localparam int unsigned CAUSE_LEN   = 5;

  typedef enum logic [ITYPE_LEN-1:0] {
    ITYPE_STD  = 4'd0,
    ITYPE_EXC  = 4'd1,
    ITYPE_INT  = 4'd2,
    ITYPE_ERET = 4'd3,
    ITYPE_NTB  = 4'd4,
    ITYPE_TB   = 4'd5,
    ITYPE_UIJ  = 4'd6
  } itype_e;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    itype_e              itype;
    logic                compressed;
    logic [PRIV_LEN-1:0] priv;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
  } exc_info_s;

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    itype_e                 itype;
    logic [PRIV_LEN-1:0]    priv;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
  } te_block_s;

  // Only exceptions and interrupts carry cause/tval into a block.
  function automatic logic is_trap(input itype_e t);
    return (t == ITYPE_EXC) || (t == ITYPE_INT);
  endfunction

endpackage

// File: rtl/te_block_builder_if.sv
// Ingress (uop FIFO head) and egress (encoder block) bundle of te_block_builder.
// The slave modport is the builder; the master modport drives it.
interface te_block_builder_if #(
  parameter int unsigned XLEN   = connector_pkg::XLEN,
  parameter int unsigned IRET_W = connector_pkg::IRETIRE_LEN
);
  import connector_pkg::*;

  logic                  uop_valid_i;
  logic                  uop_ready_o;
  uop_entry_s            uop_i;
  exc_info_s             exc_info_i;
  logic                  flush_i;
  logic                  blk_valid_o;
  logic                  blk_ready_i;
  logic [XLEN-1:0]       iaddr_o;
  logic [IRET_W-1:0]     iretire_o;
  logic                  ilastsize_o;
  logic [ITYPE_LEN-1:0]  itype_o;
  logic [PRIV_LEN-1:0]   priv_o;
  logic [CAUSE_LEN-1:0]  cause_o;
  logic [XLEN-1:0]       tval_o;

  modport slave (
    input  uop_valid_i, uop_i, exc_info_i, flush_i, blk_ready_i,
    output uop_ready_o, blk_valid_o, iaddr_o, iretire_o, ilastsize_o,
           itype_o, priv_o, cause_o, tval_o
  );

  modport master (
    output uop_valid_i, uop_i, exc_info_i, flush_i, blk_ready_i,
    input  uop_ready_o, blk_valid_o, iaddr_o, iretire_o, ilastsize_o,
           itype_o, priv_o, cause_o, tval_o
  );

endinterface

// File: rtl/te_block_builder.sv
// Groups runs of retired uops into trace-encoder instruction blocks,
// holding one finished block in a registered output slot.
module te_block_builder #(
  parameter int unsigned XLEN   = connector_pkg::XLEN,
  parameter int unsigned IRET_W = connector_pkg::IRETIRE_LEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  te_block_builder_if.slave bus
);
  import connector_pkg::*;

  localparam int unsigned CW = IRET_W + 1;
  localparam logic [CW-1:0] COUNT_MAX = {1'b0, {IRET_W{1'b1}}};

  state_e               state_q, state_d;
  logic [XLEN-1:0]      base_q, base_d;
  logic [IRET_W-1:0]    count_q, count_d;
  logic [PRIV_LEN-1:0]  priv_q, priv_d;
  logic                 last_q, last_d;
  te_block_s            slot_q, slot_d;
  logic                 bvalid_q, bvalid_d;

  logic                 slot_free_c;
  logic                 is_std_c;
  logic [CW-1:0]        size_c;
  logic [CW-1:0]        sum_c;
  logic                 close_c;
  logic                 ready_c;
  logic                 emit_c;
  te_block_s            blk_c;
  logic [CAUSE_LEN-1:0] cause_c;
  logic [XLEN-1:0]      tval_c;

  assign slot_free_c = !bvalid_q || bus.blk_ready_i;
  assign is_std_c    = (bus.uop_i.itype == ITYPE_STD);
  assign size_c      = bus.uop_i.compressed ? CW'(1) : CW'(2);
  assign sum_c       = {1'b0, count_q} + size_c;
  assign cause_c     = is_trap(bus.uop_i.itype) ? bus.exc_info_i.cause : '0;
  assign tval_c      = is_trap(bus.uop_i.itype) ? bus.exc_info_i.tval  : '0;

  // The open block must be emitted before the head uop may join anything.
  assign close_c = (state_q == COUNT) &&
                   (bus.flush_i ||
                    (bus.uop_valid_i && ((bus.uop_i.priv != priv_q) || (sum_c > COUNT_MAX))));

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    priv_d   = priv_q;
    last_d   = last_q;
    slot_d   = slot_q;
    bvalid_d = bvalid_q && !bus.blk_ready_i;
    ready_c  = 1'b0;
    emit_c   = 1'b0;
    blk_c    = '0;

    case (state_q)
      IDLE: begin
        ready_c = slot_free_c;
        if (bus.uop_valid_i && ready_c) begin
          if (is_std_c) begin
            base_d  = XLEN'(bus.uop_i.pc);
            count_d = IRET_W'(size_c);
            priv_d  = bus.uop_i.priv;
            last_d  = !bus.uop_i.compressed;
            state_d = COUNT;
          end else begin
            emit_c          = 1'b1;
            blk_c.iaddr     = bus.uop_i.pc;
            blk_c.iretire   = IRETIRE_LEN'(size_c);
            blk_c.ilastsize = !bus.uop_i.compressed;
            blk_c.itype     = bus.uop_i.itype;
            blk_c.priv      = bus.uop_i.priv;
            blk_c.cause     = cause_c;
            blk_c.tval      = tval_c;
          end
        end
      end
      COUNT: begin
        if (close_c) begin
          if (slot_free_c) begin
            emit_c          = 1'b1;
            blk_c.iaddr     = base_q;
            blk_c.iretire   = IRETIRE_LEN'(count_q);
            blk_c.ilastsize = last_q;
            blk_c.itype     = ITYPE_STD;
            blk_c.priv      = priv_q;
            state_d         = IDLE;
          end
        end else begin
          ready_c = is_std_c ? 1'b1 : slot_free_c;
          if (bus.uop_valid_i && ready_c) begin
            if (is_std_c) begin
              count_d = IRET_W'(sum_c);
              last_d  = !bus.uop_i.compressed;
            end else begin
              emit_c          = 1'b1;
              blk_c.iaddr     = base_q;
              blk_c.iretire   = IRETIRE_LEN'(IRET_W'(sum_c));
              blk_c.ilastsize = !bus.uop_i.compressed;
              blk_c.itype     = bus.uop_i.itype;
              blk_c.priv      = priv_q;
              blk_c.cause     = cause_c;
              blk_c.tval      = tval_c;
              state_d         = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new block may overwrite one being drained in the same cycle.
    if (emit_c) begin
      slot_d   = blk_c;
      bvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      priv_q   <= '0;
      last_q   <= 1'b0;
      slot_q   <= '0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      priv_q   <= priv_d;
      last_q   <= last_d;
      slot_q   <= slot_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign bus.uop_ready_o = ready_c && !rst_i;
  assign bus.blk_valid_o = bvalid_q;
  assign bus.iaddr_o     = slot_q.iaddr;
  assign bus.iretire_o   = IRET_W'(slot_q.iretire);
  assign bus.ilastsize_o = slot_q.ilastsize;
  assign bus.itype_o     = slot_q.itype;
  assign bus.priv_o      = slot_q.priv;
  assign bus.cause_o     = slot_q.cause;
  assign bus.tval_o      = slot_q.tval;

endmodule

// File: doc/te_block_builder.md
Name: te_block_builder

Overview:
- Consumes decoded uop entries popped from the uop FIFO, carrying pc, itype, compressed and priv, plus trap info.
- Groups runs of retired instructions into trace-encoder instruction blocks: start address, retired halfword count, terminating itype, priv, cause and tval.
- Sits between the uop FIFO and the trace encoder ingress port.
- Holds one output block; back-pressure is valid/ready on both sides.

Parameters:
- XLEN, connector_pkg::XLEN, address width.
- IRET_W, connector_pkg::IRETIRE_LEN (32), width of the halfword retire counter; narrowed in tests.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- uop_valid_i  in  1  FIFO head valid.
- uop_ready_o  out  1  pop FIFO head.
- uop_i  in  uop_entry_s  pc/itype/compressed/priv of head instruction.
- exc_info_i  in  exc_info_s  cause/tval; meaningful when uop_i.itype is EXC or INT.
- flush_i  in  1  force-close the open block.
- blk_valid_o  out  1  output block valid.
- blk_ready_i  in  1  encoder accepts block.
- iaddr_o  out  XLEN  address of first instruction in block.
- iretire_o  out  IRET_W  halfwords retired in block, including last instruction.
- ilastsize_o  out  1  size of last instruction: 1 = 32-bit, 0 = 16-bit.
- itype_o  out  ITYPE_LEN  itype of last instruction.
- priv_o  out  PRIV_LEN  privilege of block.
- cause_o  out  CAUSE_LEN  trap cause (0 unless itype EXC/INT).
- tval_o  out  XLEN  trap tval (0 unless itype EXC/INT).

Behaviour:
- Reset: all outputs 0, state IDLE, open-block registers (base, count, priv, lastsize) 0. Reset mid-operation discards the open and pending blocks with no emission.
- Size of an accepted uop: 1 halfword if compressed, else 2.
- Accept condition: uop accepted when uop_valid_i && uop_ready_o.
- Output slot: "free" = !blk_valid_o || blk_ready_i. The slot is a register; a block loaded at edge N appears on the outputs at N+1. Outputs hold stable while blk_valid_o && !blk_ready_i.
- State IDLE (no open block):
  - uop_ready_o = slot free.
  - Accepted STD uop: base=pc, count=size, priv=uop priv, lastsize=!compressed; go to COUNT.
  - Accepted non-STD uop: emit single-instruction block (iaddr=pc, iretire=size, itype, priv; cause/tval from exc_info_i if EXC/INT, else 0); stay IDLE.
- State COUNT (open block):
  - Close-first conditions, evaluated in this priority: flush_i; head valid with priv != open priv; count+size > 2^IRET_W-1.
  - When any close-first condition holds: uop_ready_o=0. If the slot is free, emit the open block with itype STD, ilastsize=lastsize, and go to IDLE. The head uop is processed from IDLE the next cycle.
  - Otherwise uop_ready_o = 1 for STD uops. Accepted STD: count+=size, lastsize updated; no emission; no slot requirement.
  - Otherwise uop_ready_o = slot free for non-STD uops. Accepted non-STD: emit block with iaddr=base, iretire=count+size, itype of uop, ilastsize from uop, cause/tval per the IDLE rule; go to IDLE.
- flush_i in IDLE: no effect.
- Simultaneous events:
  - Emission while the encoder drains the old block in the same cycle is allowed; the new block overwrites it with no bubble.
  - blk_ready_i with blk_valid_o=0 is ignored.
- Counter arithmetic: computed IRET_W+1 bits wide; never wraps, because saturation is handled by the close-first rule.

Decomposition:
- Add to connector_pkg: te_block_s (iaddr, iretire, ilastsize, itype, priv, cause, tval), used for the output slot register. Reuse state_e (IDLE/COUNT), itype_e, uop_entry_s and exc_info_s.
- No sub-module needed; the FSM, counter and one-entry output slot live in one module.

Test Plan:
- Four STD uops (0x1000 32-bit, 0x1004 16-bit, 0x1006 32-bit, 0x100A 32-bit), then TB at 0x100E 32-bit -> one block: iaddr=0x1000, iretire=9, itype=TB(5), ilastsize=1; uop_ready_o never drops.
- IDLE, EXC uop at 0x2000 16-bit, cause=2, tval=0xDEAD -> block iaddr=0x2000, iretire=1, itype=1, cause=2, tval=0xDEAD, ilastsize=0.
- Open block at priv 3 (two 32-bit STD from 0x3000), then STD head at priv 0 -> uop_ready_o low one cycle; block iaddr=0x3000, iretire=4, itype=STD; new block starts at the priv-0 pc.
- IRET_W=4: eight 32-bit STD uops from 0x4000 -> first block iretire=14 at iaddr=0x4000, itype STD; eighth uop begins a new block.
- Block emitted with blk_ready_i held 0 for 5 cycles, and TB uop waiting -> outputs stable, uop_ready_o=0. Ready rises -> next block loaded the same cycle, no bubble.
- Assert rst_i while in COUNT with blk_valid_o=1 -> all outputs 0 immediately; no block emitted after release.
